// File: rtl/seg_scan_reader.sv
// seg_scan_reader: recovers the hex value shown on each digit of a scanned,
// active-low seven-segment bus by deglitching {an_i, seg_i} and inverse-decoding
// every pattern that stays stable for STABLE_CYCLES consecutive samples.
// Ports: clk/rst_n (async active-low); an_i/seg_i scanned bus in; clr_i sync clear;
//   digit_o/blank_o/seen_o per-digit captured state; upd_o/upd_idx_o/bad_o capture
//   pulse, digit index and illegal flag; err_cnt_o illegal-capture count.
// Optional feature: define SEG_SCAN_READER_ERRCNT_EN to build the saturating
//   illegal-capture counter behind err_cnt_o (otherwise err_cnt_o is tied to 0).
module seg_scan_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an_i,
  input  logic [6:0]              seg_i,
  input  logic                    clr_i,
  output logic [4*NUM_DIGITS-1:0] digit_o,
  output logic [NUM_DIGITS-1:0]   blank_o,
  output logic [NUM_DIGITS-1:0]   seen_o,
  output logic                    upd_o,
  output logic [IW-1:0]           upd_idx_o,
  output logic                    bad_o,
  output logic [7:0]              err_cnt_o
);

  localparam logic [7:0] STAB = 8'(STABLE_CYCLES);

  // Current sample, its validity, and the previous sample for run comparison.
  logic [NUM_DIGITS-1:0] s_an, p_an;
  logic [6:0]            s_seg, p_seg;
  logic                  s_vld;
  logic [7:0]            run_cnt;

  logic                  in_vld;
  logic                  cont;
  logic [7:0]            run_nxt;
  logic                  capture;
  logic [IW-1:0]         idx;
  logic [3:0]            dec_val;
  logic                  dec_hex;
  logic                  dec_blank;

  logic [4*NUM_DIGITS-1:0] digit_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [NUM_DIGITS-1:0]   seen_q;
  logic                    upd_q;
  logic                    bad_q;
  logic [IW-1:0]           upd_idx_q;

  // Exactly one lit (low) anode makes a sample usable.
  always_comb begin
    in_vld = ($countones(~an_i) == 1);
  end

  // Run tracking. A non-zero counter implies the previous sample was valid, so
  // "continuing run" only needs the counter and an equality test.
  always_comb begin
    cont    = s_vld && (run_cnt != 8'd0) && (s_an == p_an) && (s_seg == p_seg);
    run_nxt = 8'd0;
    if (s_vld) begin
      if (cont) begin
        run_nxt = (run_cnt == STAB) ? run_cnt : run_cnt + 8'd1;
      end else begin
        run_nxt = 8'd1;
      end
    end
    // Capture only on the first arrival at STAB; a saturated run stays silent.
    capture = (run_nxt == STAB) && !(cont && (run_cnt == STAB)) && !clr_i;
  end

  // Position of the lit anode in the current sample.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!s_an[i]) idx = IW'(i);
    end
  end

  // Inverse decode of the active-low segment pattern.
  always_comb begin
    dec_val   = 4'h0;
    dec_hex   = 1'b1;
    dec_blank = 1'b0;
    case (s_seg)
      7'h40: dec_val = 4'h0;
      7'h79: dec_val = 4'h1;
      7'h24: dec_val = 4'h2;
      7'h30: dec_val = 4'h3;
      7'h19: dec_val = 4'h4;
      7'h12: dec_val = 4'h5;
      7'h02: dec_val = 4'h6;
      7'h78: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h18: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h03: dec_val = 4'hB;
      7'h46: dec_val = 4'hC;
      7'h21: dec_val = 4'hD;
      7'h06: dec_val = 4'hE;
      7'h0E: dec_val = 4'hF;
      7'h7F: begin
        dec_hex   = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_hex = 1'b0;
    endcase
  end

  // Sample pipeline; the validity flag keeps the all-zero reset sample invalid
  // even when NUM_DIGITS is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_an    <= '0;
      s_seg   <= '0;
      s_vld   <= 1'b0;
      p_an    <= '0;
      p_seg   <= '0;
      run_cnt <= 8'd0;
    end else begin
      s_an    <= an_i;
      s_seg   <= seg_i;
      s_vld   <= in_vld;
      p_an    <= s_an;
      p_seg   <= s_seg;
      run_cnt <= clr_i ? 8'd0 : run_nxt;
    end
  end

  // Captured per-digit state and capture pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q   <= '0;
      blank_q   <= '0;
      seen_q    <= '0;
      upd_q     <= 1'b0;
      bad_q     <= 1'b0;
      upd_idx_q <= '0;
    end else begin
      upd_q <= capture;
      bad_q <= capture && !dec_hex && !dec_blank;
      if (capture) upd_idx_q <= idx;
      if (clr_i) begin
        digit_q <= '0;
        blank_q <= '0;
        seen_q  <= '0;
      end else if (capture) begin
        if (dec_hex) begin
          digit_q[4*int'(idx) +: 4] <= dec_val;
          blank_q[idx]              <= 1'b0;
          seen_q[idx]               <= 1'b1;
        end else if (dec_blank) begin
          blank_q[idx] <= 1'b1;
          seen_q[idx]  <= 1'b1;
        end
      end
    end
  end

`ifdef SEG_SCAN_READER_ERRCNT_EN
  logic [7:0] err_cnt;

  // Counts at the capture edge, so it moves together with the data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (clr_i) begin
      err_cnt <= 8'd0;
    end else if (capture && !dec_hex && !dec_blank && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign err_cnt_o = err_cnt;
`else
  assign err_cnt_o = 8'h00;
`endif

  assign digit_o   = digit_q;
  assign blank_o   = blank_q;
  assign seen_o    = seen_q;
  assign upd_o     = upd_q;
  assign bad_o     = bad_q;
  assign upd_idx_o = upd_idx_q;

endmodule

// File: doc/seg_scan_reader.md
# seg_scan_reader

Scanned seven-segment display reader. It watches a multiplexed, active-low seven-segment bus (segments plus digit anodes) and recovers the hex value shown on each digit. It does this by deglitching the bus and inverse-decoding each stable segment pattern. It sits on the display side of the board-level segment interface and serves self-check, loopback and debug capture of whatever the hex-to-segment encoders drive.

## Interface
- `NUM_DIGITS`, default 4: number of scanned digits; legal range 1–8.
- `STABLE_CYCLES`, default 3: consecutive identical samples required before a capture; legal range 1–255.
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `an_i`, in, `NUM_DIGITS`: digit anodes, active-low. The lit digit is the single 0 bit.
- `seg_i`, in, 7: segments, active-low. Bit 0 = a through bit 6 = g.
- `clr_i`, in, 1: synchronous clear of captured state.
- `digit_o`, out, `4*NUM_DIGITS`: recovered nibble per digit. Digit n occupies `[4n+3:4n]`.
- `blank_o`, out, `NUM_DIGITS`: last capture on digit n was blank.
- `seen_o`, out, `NUM_DIGITS`: digit n has had at least one legal or blank capture.
- `upd_o`, out, 1: one-cycle pulse on every capture.
- `upd_idx_o`, out, `max(1,$clog2(NUM_DIGITS))`: digit index of the current capture.
- `bad_o`, out, 1: one-cycle pulse, coincident with `upd_o`, when the captured pattern is illegal.
- `err_cnt_o`, out, 8: illegal-capture count. See Configuration.

## Operation
- Legal active-low codes, written as `seg[6:0]` = digit:
  - 40=0, 79=1, 24=2, 30=3, 19=4, 12=5, 02=6, 78=7
  - 00=8, 18=9, 08=A, 03=b, 46=C, 21=d, 06=E, 0E=F
  - 7F = blank
- Every cycle, `{an_i, seg_i}` is registered into a sample register.
- A sample is **valid** when `an_i` has exactly one 0 bit.
- **Run counter:**
  - Increments, saturating at `STABLE_CYCLES`, while consecutive samples are valid and identical.
  - An invalid sample sets it to 0.
  - A valid sample that differs from the previous one sets it to 1.
- **Capture:** occurs exactly once per run, in the cycle the counter first reaches `STABLE_CYCLES`. A run must be broken (a change or an invalid sample) before the same digit/pattern can be captured again. Normal scanning therefore recaptures once per refresh.
- **On capture of digit n:**
  - `upd_o` = 1 and `upd_idx_o` = n.
  - Legal hex code: `digit_o[n]` = value, `blank_o[n]` = 0, `seen_o[n]` = 1.
  - 7F: `blank_o[n]` = 1, `seen_o[n]` = 1, `digit_o[n]` unchanged.
  - Any other pattern: `bad_o` = 1; `digit_o[n]`, `blank_o[n]` and `seen_o[n]` unchanged.
- **`clr_i`:**
  - Zeroes `digit_o`, `blank_o`, `seen_o`, `err_cnt_o` and the run counter.
  - Suppresses any capture in the same cycle.
  - `clr_i` has priority over capture.

## Timing
- **Reset values:** all outputs 0, run counter 0, sample register 0 (sample treated as invalid).
- **Latency:** if identical valid inputs are sampled at edges k … k+`STABLE_CYCLES`−1, the capture registers at edge k+`STABLE_CYCLES`. `upd_o`/`bad_o` are high for the following cycle only, and the data outputs update at the same edge.
- A change at any edge within the run restarts counting from that edge. No partial capture occurs.
- **Reset mid-run:** state is lost immediately. After `rst_n` rises, a full fresh run of `STABLE_CYCLES` samples is required.
- **Pulse spacing:** `upd_o` pulses are never back-to-back for the same run. The minimum spacing between pulses is `STABLE_CYCLES` cycles (with `STABLE_CYCLES`=1, one per change).

## Configuration
- Macro: `SEG_SCAN_READER_ERRCNT_EN`.
- **Defined:** `err_cnt_o` increments on each `bad_o` pulse, saturates at 255, and is cleared by `rst_n` or `clr_i`.
- **Undefined:** `err_cnt_o` is a constant 0 and no counter logic is built. All other behaviour is identical.

## Test plan
Parameters for all tests: `NUM_DIGITS`=4, `STABLE_CYCLES`=3.

1. **Basic capture:** `an_i`=1110, `seg_i`=24 held 8 cycles → a single `upd_o` pulse with `upd_idx_o`=0; `digit_o[3:0]`=2, `seen_o`=0001; no further pulses.
2. **Glitch rejection:** `an_i`=1101, `seg_i`=30 for 2 cycles, then 19 for 3 cycles → exactly one capture, `digit_o[7:4]`=4; the value 3 is never captured.
3. **Invalid anodes:** `an_i`=1100 or 1111 with `seg_i`=00 for 10 cycles → no `upd_o`; outputs unchanged.
4. **Illegal pattern:** `an_i`=0111 with `digit_o[15:12]`=A, then `seg_i`=7E held → `upd_o` and `bad_o` pulse with `upd_idx_o`=3; nibble stays A; `err_cnt_o`=1 with the macro, 0 without.
5. **Blank, then legal:** digit 1 shows 7F → `blank_o[1]`=1, `seen_o[1]`=1. It then shows 0E → `digit_o[7:4]`=F, `blank_o[1]`=0. Then `clr_i` → all captured outputs are 0.
6. **Exhaustive codes and reset:**
   - Cycle all 16 legal codes across the 4 digits → every nibble decodes correctly.
   - Drop `rst_n` after 2 samples of a run → outputs 0 immediately.
   - After release, capture occurs only after 3 new samples.
